mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
- Memory-side end of the CPU memory-controller bus.
- Accepts one read or write request at a time from the controller's address and data outputs.
- Holds `bus_full` high while the request is serviced, then returns read data or write completion with a one-cycle `ack`.
- Backed by an internal word-addressed RAM with a parameterised fixed access latency. Serves as the bus-side model and the on-chip scratch memory.

Parameters:
- `DEPTH_WORDS`, 256: number of 32-bit words in the RAM. Must be a power of two, ≥ 4.
- `LATENCY`, 2: number of edges from request acceptance to the `ack` cycle. Range 1..15.
- `INIT_FILL`, 32'h0000_0000: value written into every RAM word by the post-reset clear sweep.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `address_in`  in  32  byte address from the controller's `address_out`.
- `data_in`  in  32  write data from the controller's `data_out_BUS`.
- `read_req`  in  1  read request; level, held by the initiator until `ack`.
- `write_req`  in  1  write request; level, held by the initiator until `ack`.
- `data_out`  out  32  read data, driven to the controller's `data_in_BUS`.
- `bus_full`  out  1  responder busy; the initiator must not change its request while this is high.
- `ack`  out  1  one-cycle completion pulse.
- `err`  out  1  out-of-range flag; valid only in the `ack` cycle.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - state = CLEAR, `data_out`=0, `ack`=0, `err`=0, `bus_full`=1, counters = 0.
  - Asserting reset mid-request aborts the request. No write is committed unless its commit edge has already passed.
- FSM states: CLEAR, IDLE, WAIT, DONE.
- CLEAR:
  - Writes `INIT_FILL` to word index 0..`DEPTH_WORDS`-1, one word per edge.
  - `bus_full`=1 throughout.
  - After the last word, moves to IDLE. CLEAR therefore lasts `DEPTH_WORDS` edges.
- IDLE:
  - `bus_full`=0.
  - On an edge with `write_req`=1 or `read_req`=1, latches the address, data and operation, loads the counter with `LATENCY`-1, and moves to WAIT. If `LATENCY`=1, it moves directly to DONE.
  - When both requests are high, write wins and the read is ignored for that transaction.
- WAIT:
  - `bus_full`=1.
  - The counter decrements each edge. At 0 the FSM moves to DONE.
  - Request inputs are ignored in this state.
- DONE (exactly one cycle):
  - `ack`=1 and `bus_full`=1.
  - Next state is always IDLE.
  - The write commit and the read capture into `data_out` occur on the edge entering DONE. As a result, `data_out` is valid during the `ack` cycle.
- Timing: `ack` is high exactly `LATENCY` edges after the accepting edge.
- Back-to-back requests: if the initiator still holds a request in the first IDLE cycle after DONE, that request is accepted again. The initiator must drop its request on seeing `ack`. Minimum request-to-request spacing is `LATENCY`+1 edges.
- Addressing:
  - Word index = `address_in`[log2(`DEPTH_WORDS`)+1 : 2].
  - Bits [1:0] are ignored, so misaligned addresses access the containing word.
  - If any bit above the index range is set, the address is out of range.
- Out-of-range access:
  - Write: dropped; RAM unchanged.
  - Read: `data_out` = 32'hDEAD_BEEF.
  - Either case: `err`=1 together with `ack`.
- `data_out`:
  - Holds its last read value until the next read completes.
  - Writes do not change it.
- `err`: 0 except in the DONE cycle of an out-of-range access.

Optional Feature:
- Macro: `MEM_BUS_RESPONDER_BYTE_EN_EN`.
- Defined:
  - Adds input port `byte_en` [3:0], latched together with the request.
  - On write, only bytes whose enable bit is 1 are updated (bit 0 = bits [7:0]).
  - `byte_en`=4'b0000 completes normally with `ack` and no RAM change.
  - Reads ignore `byte_en`.
- Undefined: no `byte_en` port; every write updates all 32 bits.

Test Plan:
- Reset then wait → `bus_full`=1 for 256 edges (default depth), then 0. A read of byte address 0x40 returns 0x0000_0000 with `ack` 2 edges after acceptance and `err`=0.
- Write 0x1234_5678 to 0x10 and drop the request on `ack`; then read 0x10, then read 0x13 → both reads return 0x1234_5678. `bus_full` is high for WAIT+DONE on each transaction.
- `read_req` and `write_req` both high, address 0x20, data 0xA5A5_A5A5 → write performed. `data_out` keeps its previous value; a later read of 0x20 returns 0xA5A5_A5A5.
- Read 0x0000_0400 (out of range, depth 256) → `data_out`=0xDEAD_BEEF and `err`=1 for exactly one cycle. Write to 0x400 leaves word 0 unchanged.
- Assert `rst`=0 in the WAIT cycle of a write of 0xFFFF_FFFF to 0x08 → `ack` never pulses and `bus_full`=1 immediately. After the re-clear, reading 0x08 returns `INIT_FILL`.
- With the macro defined: write 0xFFFF_FFFF, then write 0x0000_0000 with `byte_en`=4'b0101 to 0x30 → a read returns 0xFF00_FF00. With `LATENCY`=1, `ack` comes 1 edge after acceptance.

Source files
------------

// File: rtl/mem_bus_responder.sv
// Memory-side bus responder: word-addressed RAM with fixed access latency and a post-reset clear sweep.
// Optional per-byte write enables via `MEM_BUS_RESPONDER_BYTE_EN_EN.
module mem_bus_responder #(
    parameter int unsigned DEPTH_WORDS = 256,  // power of two, >= 4
    parameter int unsigned LATENCY     = 2,    // 1..15
    parameter logic [31:0] INIT_FILL   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address_in,
    input  logic [31:0] data_in,
    input  logic        read_req,
    input  logic        write_req,
`ifdef MEM_BUS_RESPONDER_BYTE_EN_EN
    input  logic [3:0]  byte_en,
`endif
    output logic [31:0] data_out,
    output logic        bus_full,
    output logic        ack,
    output logic        err
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam int unsigned TOP      = IDX_W + 2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam logic [31:0] OOR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {CLEAR, IDLE, WAIT, DONE} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   clr_idx;
    logic [3:0]         cnt;
    logic               lat_wr, lat_oor;
    logic [IDX_W-1:0]   lat_idx;
    logic [31:0]        lat_data;
    logic [3:0]         lat_be;
    logic [31:0]        mem [DEPTH_WORDS];

    logic               req, in_oor, enter_done;
    logic [IDX_W-1:0]   in_idx;
    logic [3:0]         in_be;
    logic               op_wr, op_oor;
    logic [IDX_W-1:0]   op_idx;
    logic [31:0]        op_data;
    logic [3:0]         op_be;
    logic               addr_unused;

    assign req         = write_req | read_req;
    assign in_idx      = address_in[TOP-1:2];
    assign in_oor      = |(address_in >> TOP);
    assign addr_unused = ^address_in[1:0];

`ifdef MEM_BUS_RESPONDER_BYTE_EN_EN
    assign in_be = byte_en;
`else
    assign in_be = 4'hF;
`endif

    // With LATENCY=1 the commit edge is the accepting edge, so the live inputs are used there.
    assign op_wr   = (state == IDLE) ? write_req  : lat_wr;
    assign op_oor  = (state == IDLE) ? in_oor     : lat_oor;
    assign op_idx  = (state == IDLE) ? in_idx     : lat_idx;
    assign op_data = (state == IDLE) ? data_in    : lat_data;
    assign op_be   = (state == IDLE) ? in_be      : lat_be;

    assign enter_done = (state_nxt == DONE) && (state != DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= CLEAR;
        else      state <= state_nxt;
    end

    // The counter reaching 0 on this edge is what moves WAIT to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR: if (clr_idx == '1) state_nxt = IDLE;
            IDLE:  if (req) state_nxt = (LATENCY == 1) ? DONE : WAIT;
            WAIT:  if (cnt == 4'd1) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        bus_full = (state != IDLE);
        ack      = (state == DONE);
        err      = (state == DONE) && lat_oor;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_idx  <= '0;
            cnt      <= '0;
            lat_wr   <= 1'b0;
            lat_oor  <= 1'b0;
            lat_idx  <= '0;
            lat_data <= '0;
            lat_be   <= '0;
            data_out <= '0;
        end else begin
            if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
            if (state == IDLE && req) begin
                lat_wr   <= write_req;
                lat_oor  <= in_oor;
                lat_idx  <= in_idx;
                lat_data <= data_in;
                lat_be   <= in_be;
                cnt      <= CNT_INIT;
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
            end
            if (enter_done && !op_wr)
                data_out <= op_oor ? OOR_DATA : mem[op_idx];
        end
    end

    // RAM has no reset; it is initialised by the CLEAR sweep. Gating on rst keeps an
    // in-flight write from committing once reset is asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == CLEAR) begin
                mem[clr_idx] <= INIT_FILL;
            end else if (enter_done && op_wr && !op_oor) begin
                for (int b = 0; b < 4; b++)
                    if (op_be[b]) mem[op_idx][8*b +: 8] <= op_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized self-checking bench for mem_bus_responder against an array-based memory model.
module tb_mem_bus_responder;

    localparam int          DEPTH = 256;
    localparam int          LAT   = 2;
    localparam logic [31:0] FILL  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address_in, data_in;
    logic        read_req, write_req;
    logic [31:0] data_out;
    logic        bus_full, ack, err;
`ifdef MEM_BUS_RESPONDER_BYTE_EN_EN
    logic [3:0]  byte_en;
`endif

    mem_bus_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .INIT_FILL(FILL)) dut (
        .clk(clk), .rst(rst), .address_in(address_in), .data_in(data_in),
        .read_req(read_req), .write_req(write_req),
`ifdef MEM_BUS_RESPONDER_BYTE_EN_EN
        .byte_en(byte_en),
`endif
        .data_out(data_out), .bus_full(bus_full), .ack(ack), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref_dout;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = FILL;
        ref_dout = 32'h0;
    endtask

    // Starts and ends at a negedge, right after reset has been released.
    task automatic clear_check();
        int n = 0;
        bit idle = 0;
        while (!idle && n < DEPTH + 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!bus_full) idle = 1;
        end
        chk("clear_len", n, DEPTH);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus_full !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (bus_full !== 1'b0) chk("idle_timeout", bus_full, 0);
    endtask

    task automatic txn(input bit wr, input bit rd, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be);
        int  n = 0;
        bit  seen = 0;
        bit  oor;
        int  idx;
        logic [3:0] eff_be;
        wait_idle();
        oor = (addr >= 32'(DEPTH * 4));
        idx = int'((addr >> 2) % DEPTH);
`ifdef MEM_BUS_RESPONDER_BYTE_EN_EN
        eff_be  = be;
        byte_en = be;
`else
        eff_be  = 4'hF;
`endif
        address_in = addr;
        data_in    = data;
        write_req  = wr;
        read_req   = rd;
        while (!seen && n < LAT + 5) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            chk("busy_in_txn", bus_full, 1);
            if (ack) seen = 1;
        end
        chk("ack_latency", n, LAT);
        if (wr) begin
            if (!oor)
                for (int b = 0; b < 4; b++)
                    if (eff_be[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
        end else begin
            ref_dout = oor ? 32'hDEAD_BEEF : ref_mem[idx];
        end
        chk("err_at_ack", err, oor);
        chk("data_out", data_out, ref_dout);
        write_req = 0;
        read_req  = 0;
        @(negedge clk);
        chk("ack_one_cycle", ack, 0);
        chk("err_one_cycle", err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; read_req = 0; write_req = 0; address_in = 0; data_in = 0;
`ifdef MEM_BUS_RESPONDER_BYTE_EN_EN
        byte_en = 4'hF;
`endif
        model_reset();
        #2 rst = 0;
        #1;
        chk("rst_bus_full", bus_full, 1);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_data_out", data_out, 0);
        repeat (2) @(negedge clk);
        rst = 1;
        clear_check();

        // Directed cases
        txn(0, 1, 32'h40, 0, 4'hF);
        txn(1, 0, 32'h10, 32'h1234_5678, 4'hF);
        txn(0, 1, 32'h10, 0, 4'hF);
        chk("rd_0x10", data_out, 32'h1234_5678);
        txn(0, 1, 32'h13, 0, 4'hF);
        chk("rd_0x13", data_out, 32'h1234_5678);
        txn(1, 1, 32'h20, 32'hA5A5_A5A5, 4'hF);
        chk("both_keeps_dout", data_out, 32'h1234_5678);
        txn(0, 1, 32'h20, 0, 4'hF);
        chk("rd_0x20", data_out, 32'hA5A5_A5A5);
        txn(0, 1, 32'h400, 0, 4'hF);
        chk("oor_read", data_out, 32'hDEAD_BEEF);
        txn(1, 0, 32'h400, 32'hCAFE_F00D, 4'hF);
        txn(0, 1, 32'h0, 0, 4'hF);
        txn(1, 0, 32'h3FF, 32'h0BAD_F00D, 4'hF);
        txn(0, 1, 32'h3FC, 0, 4'hF);
        chk("last_word", data_out, 32'h0BAD_F00D);
`ifdef MEM_BUS_RESPONDER_BYTE_EN_EN
        txn(1, 0, 32'h30, 32'hFFFF_FFFF, 4'hF);
        txn(1, 0, 32'h30, 32'h0000_0000, 4'b0101);
        txn(0, 1, 32'h30, 0, 4'hF);
        chk("byte_en_0101", data_out, 32'hFF00_FF00);
        txn(1, 0, 32'h30, 32'h1111_1111, 4'b0000);
        txn(0, 1, 32'h30, 0, 4'hF);
        chk("byte_en_none", data_out, 32'hFF00_FF00);
`endif

        // Randomized traffic
        for (int t = 0; t < 120; t++) begin
            int unsigned op = $urandom_range(0, 2);
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_0400;
            else if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 63));
            else a = 32'($urandom_range(0, DEPTH * 4 - 1));
            txn(op != 0, op != 1, a, $urandom, 4'($urandom_range(0, 15)));
        end

        // Reset during the WAIT cycle of a write aborts it
        wait_idle();
        address_in = 32'h08; data_in = 32'hFFFF_FFFF; write_req = 1; read_req = 0;
`ifdef MEM_BUS_RESPONDER_BYTE_EN_EN
        byte_en = 4'hF;
`endif
        @(posedge clk);
        @(negedge clk);
        chk("wait_busy", bus_full, 1);
        rst = 0;
        #1;
        chk("abort_bus_full", bus_full, 1);
        chk("abort_ack", ack, 0);
        chk("abort_data_out", data_out, 0);
        write_req = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_ack", ack, 0);
        end
        rst = 1;
        model_reset();
        clear_check();
        txn(0, 1, 32'h08, 0, 4'hF);
        chk("post_abort_rd", data_out, FILL);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
